// File: rtl/debug_mem_access_pkg.sv
// Shared types and jdo field positions for the debug memory access controller.
`default_nettype none

package debug_mem_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int         JDO_RD_FLAG_BIT = 35;
  localparam int         JDO_WDATA_LSB   = 3;
  localparam int         JDO_ADDR_LSB    = 2;
  localparam logic [3:0] BYTEENABLE_ALL  = 4'hF;

endpackage

`default_nettype wire

// File: rtl/debug_timeout_counter.sv
// Watchdog cycle counter; tc_o flags the cycle in which the count reaches TIMEOUT.
`default_nettype none

module debug_timeout_counter
  import debug_mem_access_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The enabled cycle that would bring the count to TIMEOUT is the abort cycle.
  assign tc_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/debug_mem_access_ctrl.sv
// Turns JTAG debug commands into single-word reads/writes on a memory-mapped master port.
`default_nettype none

module debug_mem_access_ctrl
  import debug_mem_access_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic [3:0]        mem_byteenable,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_readdatavalid
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       mondreg_q, mondreg_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              launch, abort, active, any_strobe, tmo;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[1:0]};
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign active     = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT) || (state_q == ST_WR_REQ);

  debug_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i  (clk),
    .rst_n_i(reset_n),
    .clear_i(launch),
    .en_i   (active),
    .tc_o   (tmo)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mondreg_d = mondreg_q;
    wdata_d   = wdata_q;
    ready_d   = ready_q;
    error_d   = error_q;
    launch    = 1'b0;
    abort     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (take_action_ocimem_b) begin
          wdata_d = jdo[JDO_WDATA_LSB +: 32];
          state_d = ST_WR_REQ;
          launch  = 1'b1;
        end else if (take_action_ocimem_a) begin
          addr_d  = jdo[JDO_ADDR_LSB +: ADDR_W];
          ready_d = 1'b1;
          error_d = 1'b0;
          if (jdo[JDO_RD_FLAG_BIT]) begin
            state_d = ST_RD_REQ;
            launch  = 1'b1;
          end
        end else if (take_no_action_ocimem_a) begin
          state_d = ST_RD_REQ;
          launch  = 1'b1;
        end
      end
      ST_RD_REQ: begin
        // Data may arrive together with acceptance; skip RD_WAIT then.
        if (!mem_waitrequest) begin
          if (mem_readdatavalid) begin
            mondreg_d = mem_readdata;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end else if (tmo) begin
          abort = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (mem_readdatavalid) begin
          mondreg_d = mem_readdata;
          state_d   = ST_DONE;
        end else if (tmo) begin
          abort = 1'b1;
        end
      end
      ST_WR_REQ: begin
        if (!mem_waitrequest) begin
          state_d = ST_DONE;
        end else if (tmo) begin
          abort = 1'b1;
        end
      end
      ST_DONE: begin
        ready_d = 1'b1;
        addr_d  = addr_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (launch) begin
      ready_d = 1'b0;
      error_d = 1'b0;
    end
    if (any_strobe && (state_q != ST_IDLE)) begin
      error_d = 1'b1;
    end
    if (abort) begin
      ready_d = 1'b1;
      error_d = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      mondreg_q <= '0;
      wdata_q   <= '0;
      ready_q   <= 1'b1;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      mondreg_q <= mondreg_d;
      wdata_q   <= wdata_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
    end
  end

  assign MonDReg        = mondreg_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = error_q;
  assign busy           = (state_q != ST_IDLE);
  assign mem_address    = addr_q;
  assign mem_read       = (state_q == ST_RD_REQ);
  assign mem_write      = (state_q == ST_WR_REQ);
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = BYTEENABLE_ALL;

endmodule

`default_nettype wire

// File: tb/tb_debug_mem_access_ctrl.sv
// Scoreboard bench: bus requests and command completions are checked against queued expectations.
`default_nettype none

module tb_debug_mem_access_ctrl;

  typedef struct packed {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] dreg;
    logic        err;
    logic [9:0]  addr;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        ta = 1'b0, tb = 1'b0, tn = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, busy;
  logic [9:0]  mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] mem_readdata = '0;
  logic        mem_readdatavalid = 1'b0;

  int checks = 0;
  int errors = 0;

  req_t  req_q[$];
  resp_t resp_q[$];

  // slave behaviour knobs
  int          slave_waits = 0;
  int          rdv_delay = 1;
  logic        hang = 1'b0;
  logic [31:0] slave_data = '0;
  logic        force_rdv = 1'b0;
  logic [31:0] force_data = '0;
  logic        mon_en = 1'b0;

  always #5 clk = ~clk;

  debug_mem_access_ctrl #(
    .ADDR_W (10),
    .TIMEOUT(8)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (ta),
    .take_action_ocimem_b   (tb),
    .take_no_action_ocimem_a(tn),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error),
    .busy                   (busy),
    .mem_address            (mem_address),
    .mem_read               (mem_read),
    .mem_write              (mem_write),
    .mem_writedata          (mem_writedata),
    .mem_byteenable         (mem_byteenable),
    .mem_waitrequest        (mem_waitrequest),
    .mem_readdata           (mem_readdata),
    .mem_readdatavalid      (mem_readdatavalid)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model followed by the monitor, both evaluated on the falling edge.
  initial begin : slave_and_monitor
    int   wait_cnt = 0;
    int   rdv_cnt = 0;
    logic ready_prev = 1'b1;
    req_t  er;
    resp_t ep;
    forever begin
      @(negedge clk);
      mem_readdatavalid = 1'b0;
      if (rdv_cnt > 0) begin
        rdv_cnt--;
        if (rdv_cnt == 0) begin
          mem_readdatavalid = 1'b1;
          mem_readdata = slave_data;
        end
      end
      if (force_rdv) begin
        mem_readdatavalid = 1'b1;
        mem_readdata = force_data;
      end
      if (mem_read || mem_write) begin
        if (hang || wait_cnt < slave_waits) begin
          mem_waitrequest = 1'b1;
          wait_cnt++;
        end else begin
          mem_waitrequest = 1'b0;
          wait_cnt = 0;
          if (mem_read) begin
            if (rdv_delay == 0) begin
              mem_readdatavalid = 1'b1;
              mem_readdata = slave_data;
            end else begin
              rdv_cnt = rdv_delay;
            end
          end
        end
      end else begin
        mem_waitrequest = 1'b0;
        wait_cnt = 0;
      end

      if (mon_en) begin
        if ((mem_read || mem_write) && !mem_waitrequest) begin
          if (req_q.size() == 0) begin
            chk("unexpected_req", {mem_write, mem_address}, '1);
          end else begin
            er = req_q.pop_front();
            chk("req_kind", 64'(mem_write), 64'(er.wr));
            chk("req_addr", 64'(mem_address), 64'(er.addr));
            if (er.wr) chk("req_wdata", 64'(mem_writedata), 64'(er.wdata));
          end
        end
        if (monitor_ready && !ready_prev) begin
          if (resp_q.size() == 0) begin
            chk("unexpected_done", 64'(MonDReg), '1);
          end else begin
            ep = resp_q.pop_front();
            chk("done_mondreg", 64'(MonDReg), 64'(ep.dreg));
            chk("done_error", 64'(monitor_error), 64'(ep.err));
            chk("done_addr", 64'(mem_address), 64'(ep.addr));
          end
        end
      end
      ready_prev = monitor_ready;
    end
  end

  function automatic logic [37:0] jdo_addr(input logic [9:0] a, input logic rd);
    logic [37:0] v;
    v = '0;
    v[11:2] = a;
    v[35] = rd;
    return v;
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    logic [37:0] v;
    v = '0;
    v[34:3] = d;
    return v;
  endfunction

  task automatic cmd(input logic a, input logic b, input logic n, input logic [37:0] d);
    jdo = d; ta = a; tb = b; tn = n;
    @(negedge clk);
    ta = 1'b0; tb = 1'b0; tn = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 40 && busy; k++) @(negedge clk);
    if (busy) chk({name, "_idle_timeout"}, 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  task automatic count_active(input logic wr, output int n);
    n = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      if (wr ? mem_write : mem_read) n++;
      @(negedge clk);
    end
  endtask

  initial begin : stim
    int n;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_mondreg", 64'(MonDReg), 64'd0);
    chk("rst_ready", 64'(monitor_ready), 64'd1);
    chk("rst_error", 64'(monitor_error), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdwr", {mem_read, mem_write}, 64'd0);
    chk("rst_addr", 64'(mem_address), 64'd0);
    chk("rst_wdata", 64'(mem_writedata), 64'd0);
    chk("byteenable", 64'(mem_byteenable), 64'hF);
    mon_en = 1'b1;

    // load-and-read with latency profile
    slave_data = 32'hCAFEF00D;
    req_q.push_back('{wr: 1'b0, addr: 10'h010, wdata: 32'h0});
    resp_q.push_back('{dreg: 32'hCAFEF00D, err: 1'b0, addr: 10'h011});
    cmd(1'b1, 1'b0, 1'b0, jdo_addr(10'h010, 1'b1));
    chk("lat_c1_ready", 64'(monitor_ready), 64'd0);
    chk("lat_c1_busy", 64'(busy), 64'd1);
    chk("lat_c1_read", 64'(mem_read), 64'd1);
    @(negedge clk);
    chk("lat_c2_ready", 64'(monitor_ready), 64'd0);
    chk("lat_c2_read", 64'(mem_read), 64'd0);
    @(negedge clk);
    chk("lat_c3_ready", 64'(monitor_ready), 64'd0);
    @(negedge clk);
    chk("lat_c4_ready", 64'(monitor_ready), 64'd1);
    wait_idle("load_read");

    // write with three stall cycles, then read-next
    slave_waits = 3;
    req_q.push_back('{wr: 1'b1, addr: 10'h011, wdata: 32'h12345678});
    resp_q.push_back('{dreg: 32'hCAFEF00D, err: 1'b0, addr: 10'h012});
    cmd(1'b0, 1'b1, 1'b0, jdo_data(32'h12345678));
    count_active(1'b1, n);
    chk("write_cycles", 64'(n), 64'd4);
    wait_idle("write");
    slave_waits = 0;
    slave_data = 32'hA5A50001;
    req_q.push_back('{wr: 1'b0, addr: 10'h012, wdata: 32'h0});
    resp_q.push_back('{dreg: 32'hA5A50001, err: 1'b0, addr: 10'h013});
    cmd(1'b0, 1'b0, 1'b1, '0);
    wait_idle("read_next");

    // address wrap
    cmd(1'b1, 1'b0, 1'b0, jdo_addr(10'h3FF, 1'b0));
    chk("load_only_busy", 64'(busy), 64'd0);
    chk("load_only_addr", 64'(mem_address), 64'h3FF);
    chk("load_only_ready", 64'(monitor_ready), 64'd1);
    req_q.push_back('{wr: 1'b1, addr: 10'h3FF, wdata: 32'hDEADBEEF});
    resp_q.push_back('{dreg: 32'hA5A50001, err: 1'b0, addr: 10'h000});
    cmd(1'b0, 1'b1, 1'b0, jdo_data(32'hDEADBEEF));
    wait_idle("wrap_write");
    slave_data = 32'h0BADC0DE;
    req_q.push_back('{wr: 1'b0, addr: 10'h000, wdata: 32'h0});
    resp_q.push_back('{dreg: 32'h0BADC0DE, err: 1'b0, addr: 10'h001});
    cmd(1'b0, 1'b0, 1'b1, '0);
    wait_idle("wrap_read");

    // watchdog abort
    cmd(1'b1, 1'b0, 1'b0, jdo_addr(10'h020, 1'b0));
    hang = 1'b1;
    resp_q.push_back('{dreg: 32'h0BADC0DE, err: 1'b1, addr: 10'h020});
    cmd(1'b0, 1'b0, 1'b1, '0);
    count_active(1'b0, n);
    chk("timeout_read_cycles", 64'(n), 64'd8);
    chk("timeout_busy", 64'(busy), 64'd0);
    chk("timeout_error", 64'(monitor_error), 64'd1);
    hang = 1'b0;
    @(negedge clk);

    // overrun: write strobe while a read waits for data
    rdv_delay = 3;
    slave_data = 32'h11112222;
    req_q.push_back('{wr: 1'b0, addr: 10'h040, wdata: 32'h0});
    resp_q.push_back('{dreg: 32'h11112222, err: 1'b1, addr: 10'h041});
    cmd(1'b1, 1'b0, 1'b0, jdo_addr(10'h040, 1'b1));
    @(negedge clk);
    cmd(1'b0, 1'b1, 1'b0, jdo_data(32'hFFFF0000));
    chk("overrun_error", 64'(monitor_error), 64'd1);
    wait_idle("overrun");
    rdv_delay = 0;
    // next accepted command clears the error; data arrives with acceptance
    slave_data = 32'h5A5A5A5A;
    req_q.push_back('{wr: 1'b0, addr: 10'h050, wdata: 32'h0});
    resp_q.push_back('{dreg: 32'h5A5A5A5A, err: 1'b0, addr: 10'h051});
    cmd(1'b1, 1'b0, 1'b0, jdo_addr(10'h050, 1'b1));
    chk("clear_error", 64'(monitor_error), 64'd0);
    wait_idle("same_cycle_rdv");
    rdv_delay = 1;

    // reset in the middle of a read, then a stale readdatavalid
    hang = 1'b1;
    resp_q.push_back('{dreg: 32'h0, err: 1'b0, addr: 10'h000});
    cmd(1'b1, 1'b0, 1'b0, jdo_addr(10'h060, 1'b1));
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_read", 64'(mem_read), 64'd0);
    chk("mid_rst_mondreg", 64'(MonDReg), 64'd0);
    chk("mid_rst_ready", 64'(monitor_ready), 64'd1);
    hang = 1'b0;
    force_data = 32'hBAD0BAD0;
    @(posedge clk);
    force_rdv = 1'b1;
    @(posedge clk);
    force_rdv = 1'b0;
    repeat (2) @(negedge clk);
    chk("stale_rdv_mondreg", 64'(MonDReg), 64'd0);
    chk("stale_rdv_busy", 64'(busy), 64'd0);

    chk("req_queue_drained", 64'(req_q.size()), 64'd0);
    chk("resp_queue_drained", 64'(resp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/debug_mem_access_ctrl.md
Name: debug_mem_access_ctrl

Overview:
Sysclk-domain consumer of the debug slave wrapper's jdo bus and take_action_ocimem_a, take_action_ocimem_b and take_no_action_ocimem_a strobes. It turns JTAG debug commands into word reads and writes on a memory-mapped master port with waitrequest/readdatavalid handshakes. It returns results on MonDReg, monitor_ready and monitor_error, which feed the wrapper's MonDReg, monitor_ready and monitor_error inputs. A watchdog counter aborts stalled accesses.

Parameters:
ADDR_W, 10, word-address width of mem_address.
TIMEOUT, 255, max cycles a transaction may stay outstanding before abort (1..65535).

Ports:
clk  in  1  system clock, sole clock.
reset_n  in  1  reset, synchronous, active-low.
jdo  in  38  debug command payload from wrapper.
take_action_ocimem_a  in  1  load-address command strobe, 1 cycle.
take_action_ocimem_b  in  1  write command strobe, 1 cycle.
take_no_action_ocimem_a  in  1  read-next command strobe, 1 cycle.
MonDReg  out  32  last read data.
monitor_ready  out  1  last command finished.
monitor_error  out  1  last command aborted or dropped.
busy  out  1  transaction in flight (state != IDLE).
mem_address  out  ADDR_W  word address.
mem_read  out  1  read request.
mem_write  out  1  write request.
mem_writedata  out  32  write data.
mem_byteenable  out  4  constant 4'hF.
mem_waitrequest  in  1  slave stall.
mem_readdata  in  32  read data.
mem_readdatavalid  in  1  read data qualifier.

Behaviour:
- Interface decision: one clock (clk); reset_n is synchronous and active-low.
- Reset values: MonDReg=0, monitor_ready=1, monitor_error=0, busy=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, addr register=0, timeout counter=0.
- Reset mid-transaction: the next edge forces IDLE and all reset values. Late mem_readdatavalid after reset is ignored.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- Strobe priority when more than one strobe is asserted in a cycle: ocimem_b > ocimem_a > no_action_ocimem_a.
- ocimem_a, accepted in IDLE:
  - addr <= jdo[ADDR_W+1:2].
  - If jdo[35]=1, go to RD_REQ at addr. Otherwise stay in IDLE.
  - In both cases: monitor_ready<=1 unless a read launches; monitor_error<=0.
- ocimem_b, accepted in IDLE: mem_writedata <= jdo[34:3]; go to WR_REQ.
- no_action_ocimem_a, accepted in IDLE: go to RD_REQ at addr.
- Any accepted launch clears monitor_ready and monitor_error in the same edge.
- Command strobe while not IDLE: dropped; monitor_error <= 1 (sticky until the next accepted command); the transaction in flight continues.
- RD_REQ: mem_read=1, mem_address=addr, held while mem_waitrequest=1. First cycle with mem_waitrequest=0 -> RD_WAIT.
- RD_WAIT: mem_read=0. On mem_readdatavalid: MonDReg <= mem_readdata; go to DONE.
- readdatavalid in the same cycle as request acceptance is legal: capture the data and go straight to DONE.
- WR_REQ: mem_write=1, held while mem_waitrequest=1. On acceptance -> DONE.
- DONE, one cycle:
  - monitor_ready <= 1.
  - addr <= addr+1, modulo 2^ADDR_W (all-ones wraps to 0). Increments after every completed read or write, not after an abort.
  - Next state IDLE.
- Latency from a read strobe with zero-wait slave and readdatavalid one cycle after acceptance: strobe at edge 0, mem_read cycle 1, data cycle 2, monitor_ready high after edge 3.
- Timeout:
  - Counter clears on launch and increments in every RD_REQ, RD_WAIT and WR_REQ cycle.
  - On reaching TIMEOUT: deassert mem_read/mem_write, monitor_error<=1, monitor_ready<=1, MonDReg unchanged, addr unchanged, next state IDLE.
  - Completion and timeout in the same cycle: completion wins.
- busy = (state != IDLE).

Decomposition:
- Package debug_mem_access_pkg holds the state enum, JDO_RD_FLAG_BIT=35, JDO_WDATA_LSB=3, JDO_ADDR_LSB=2 and BYTEENABLE_ALL=4'hF.
- One sub-module, debug_timeout_counter: clear, enable and terminal-count output, width clog2(TIMEOUT+1).

Test Plan:
- Load/read: ocimem_a with jdo[11:2]=10'h010, jdo[35]=1; slave returns 32'hCAFEF00D one cycle after acceptance -> mem_address=0x010, MonDReg=CAFEF00D, monitor_ready rises edge 3, addr=0x011.
- Write then read-next: ocimem_b with jdo[34:3]=32'h12345678 at addr 0x011, slave 3 waitrequest cycles -> mem_write high 4 cycles, writedata correct, addr=0x012. Then no_action_ocimem_a issues a read at 0x012.
- Wrap: load addr 10'h3FF and write -> addr becomes 0x000. A following read-next targets 0x000.
- Timeout: TIMEOUT=8, slave holds waitrequest forever -> mem_read drops after 8 cycles, monitor_error=1, monitor_ready=1, addr unchanged, busy=0.
- Overrun: ocimem_b strobe during RD_WAIT -> no write issued, read completes normally, monitor_error=1. The next accepted ocimem_a clears the error.
- Reset mid-read: reset_n low for 1 cycle in RD_REQ -> next edge mem_read=0, MonDReg=0, monitor_ready=1. Stale readdatavalid afterward leaves MonDReg at 0.
